// File: rtl/ysyx_23060096_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060096_div_pkg
// Brief    : Shared constants and state encoding for the RV32M divide sequencer.
// Revision : 1.0
// ============================================================================
package ysyx_23060096_div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  DIV0_QUOT = 32'hFFFF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060096_adder.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060096_adder
// Brief    : XLEN-bit add/sub unit; op=1 computes a-b with carry=1 meaning no borrow.
// Revision : 1.0
// ============================================================================
module ysyx_23060096_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            op,
    output logic [XLEN-1:0] result,
    output logic            carry
);

    logic [XLEN-1:0] w_b_eff;

    assign w_b_eff = b ^ {XLEN{op}};
    assign {carry, result} = {1'b0, a} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, op};

endmodule
`default_nettype wire

// File: rtl/ysyx_23060096_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060096_div_ctrl
// Brief    : Restoring-division sequencer for DIV/DIVU/REM/REMU on one shared
//            subtractor. Early-exit for |dividend| < |divisor| is enabled by
//            the macro YSYX_23060096_DIV_EARLY_EN.
// Revision : 1.0
// ============================================================================
module ysyx_23060096_div_ctrl
    import ysyx_23060096_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_dsr;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;

    logic [XLEN-1:0]  w_dvd_abs;
    logic [XLEN-1:0]  w_dsr_abs;
    logic [XLEN-1:0]  w_t;
    logic [XLEN-1:0]  w_a;
    logic [XLEN-1:0]  w_b;
    logic [XLEN-1:0]  w_sum;
    logic             w_carry;
    logic             w_take;

    assign w_dvd_abs = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
    assign w_dsr_abs = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
    assign w_t       = {r_rem[XLEN-2:0], r_q[XLEN-1]};
    // The bit shifted out of rem makes t exceed any 32-bit divisor, so it forces a subtract.
    assign w_take    = r_rem[XLEN-1] | w_carry;

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_state)
            ST_CALC: begin
                w_a = w_t;
                w_b = r_dsr;
            end
            ST_FIX: begin
                w_b = (r_cnt == '0) ? r_q : r_rem;
            end
`ifdef YSYX_23060096_DIV_EARLY_EN
            ST_IDLE: begin
                w_a = w_dvd_abs;
                w_b = w_dsr_abs;
            end
`endif
            default: begin
                w_a = '0;
                w_b = '0;
            end
        endcase
    end

    ysyx_23060096_adder #(
        .XLEN   (XLEN)
    ) u_adder (
        .a      (w_a),
        .b      (w_b),
        .op     (1'b1),
        .result (w_sum),
        .carry  (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_dbz   <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_q_neg <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        r_r_neg <= is_signed & dividend[XLEN-1];
                        r_dsr   <= w_dsr_abs;
                        if (divisor == '0) begin
                            r_q     <= DIV0_QUOT;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                            r_state <= ST_DONE;
`ifdef YSYX_23060096_DIV_EARLY_EN
                        end else if (!w_carry) begin
                            r_q     <= '0;
                            r_rem   <= w_dvd_abs;
                            r_dbz   <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= ST_FIX;
`endif
                        end else begin
                            r_q     <= w_dvd_abs;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_cnt   <= CNT_INIT;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_take ? w_sum : w_t;
                    r_q   <= {r_q[XLEN-2:0], w_take};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Counter 0 selects the quotient pass, 1 the remainder pass.
                    if (r_cnt == '0) begin
                        if (r_q_neg) begin
                            r_q <= w_sum;
                        end
                        r_cnt <= CNT_W'(1);
                    end else begin
                        if (r_r_neg) begin
                            r_rem <= w_sum;
                        end
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060096_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060096_div_ctrl
// Brief    : Directed scoreboard bench for the divide sequencer.
// Revision : 1.0
// ============================================================================
module tb_ysyx_23060096_div_ctrl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    exp_t sb[$];
    int   n_total  = 0;
    int   n_passed = 0;

    always #5 clk = ~clk;

    ysyx_23060096_div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic [31:0] aa, ab;
        aa = (s && a[31]) ? -a : a;
        ab = (s && b[31]) ? -b : b;
        e.dbz = 1'b0;
        e.lat = 35;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = 32'd0;
            end else if (s) begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
`ifdef YSYX_23060096_DIV_EARLY_EN
            if (aa < ab) e.lat = 3;
`endif
        end
        return e;
    endfunction

    // Present one request for exactly one edge; optionally record its expectation.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        if (push) sb.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (called right after send) and compare against the scoreboard head.
    task automatic collect(input string tag);
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({tag, "_quot"}, quotient, e.q);
            chk({tag, "_rem"}, remainder, e.r);
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        send(a, b, s, 1'b1);
        collect(tag);
        release_result(tag);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("divu_100_7", 32'd100, 32'd7, 1'b0);
        run("div_m7_2", -32'sd7, 32'd2, 1'b1);
        run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run("remu_5_0", 32'd5, 32'd0, 1'b0);
        run("div_m5_0", -32'sd5, 32'd0, 1'b1);
        run("divu_3_10", 32'd3, 32'd10, 1'b0);
        run("div_7_m2", 32'd7, -32'sd2, 1'b1);
        run("divu_big", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run("divu_big2", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
        run("div_m3_m10", -32'sd3, -32'sd10, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run("rand", $urandom, $urandom >> (i * 5), i[0]);
        end

        // Backpressure: result must hold while out_ready stays low.
        send(32'd50, 32'd5, 1'b0, 1'b1);
        collect("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_quot", quotient, 32'd10);
            chk("bp_hold_rem", remainder, 32'd0);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        release_result("bp");

        // Flush coincident with an accept drops the request.
        @(negedge clk);
        in_valid  = 1'b1;
        dividend  = 32'd9;
        divisor   = 32'd0;
        is_signed = 1'b0;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_accept_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_accept_valid", {31'd0, out_valid}, 32'd0);

        // Flush at CALC step 10.
        send(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_calc_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_calc_no_valid", 32'(seen), 32'd0);

        // Reset mid-CALC.
        send(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_quot", quotient, 32'd0);
        chk("rst_mid_rem", remainder, 32'd0);
        chk("rst_mid_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("post_rst", 32'd1000, 32'd3, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
`default_nettype wire
